// File: rtl/div_pkg.sv
// Shared types for the sequential divider: FSM state encoding and algorithm select codes.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ITER,
    CORRECT,
    FIXUP,
    DONE
  } state_t;

  localparam logic MODE_RESTORING    = 1'b0;
  localparam logic MODE_NONRESTORING = 1'b1;

endpackage

// File: rtl/div_addsub_stage.sv
// (WIDTH+1)-bit adder/subtractor shared by the iteration and correction steps of the divider.
module div_addsub_stage
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] i_a,
  input  logic [WIDTH:0] i_b,
  input  logic           i_sub,
  output logic [WIDTH:0] o_sum,
  output logic           o_sign
);

  assign o_sum  = i_sub ? (i_a - i_b) : (i_a + i_b);
  assign o_sign = o_sum[WIDTH];

endmodule

// File: rtl/seq_divider_param.sv
// Multi-cycle WIDTH-bit divider, restoring or non-restoring per operation, with signed support,
// divide-by-zero and signed-overflow flags, behind a start/done/gotResult handshake.
module seq_divider_param
  import div_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             gotResult,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mode;
  logic             r_sgn;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;
  logic             r_ovf;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic             w_dvs_zero;
  logic             w_ovf;
  logic [WIDTH:0]   w_a_sh;
  logic [WIDTH-2:0] w_q_sh;
  logic [WIDTH:0]   w_as_a;
  logic [WIDTH:0]   w_as_b;
  logic             w_as_sub;
  logic [WIDTH:0]   w_as_sum;
  logic             w_as_sign;

  assign w_dvd_neg  = r_sgn & r_dvd[WIDTH-1];
  assign w_dvs_neg  = r_sgn & r_dvs[WIDTH-1];
  assign w_dvd_mag  = w_dvd_neg ? -r_dvd : r_dvd;
  assign w_dvs_mag  = w_dvs_neg ? -r_dvs : r_dvs;
  assign w_dvs_zero = (r_dvs == '0);
  assign w_ovf      = r_sgn && (r_dvd == MIN_NEG) && (r_dvs == '1);
  assign w_a_sh     = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_q_sh     = r_q[WIDTH-2:0];
  assign w_as_b     = {1'b0, r_m};

  // ITER works on the shifted A; CORRECT adds M back to the unshifted A.
  always_comb begin
    w_as_a   = w_a_sh;
    w_as_sub = 1'b1;
    if (r_state == CORRECT) begin
      w_as_a   = r_a;
      w_as_sub = 1'b0;
    end else if (r_mode == MODE_NONRESTORING) begin
      w_as_sub = ~r_a[WIDTH];
    end
  end

  div_addsub_stage #(.WIDTH(WIDTH)) u_addsub (
    .i_a    (w_as_a),
    .i_b    (w_as_b),
    .i_sub  (w_as_sub),
    .o_sum  (w_as_sum),
    .o_sign (w_as_sign)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // A zero divisor skips the iterations; FIXUP is the single load point for the result registers.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = INIT;
      INIT:    w_state_nxt = w_dvs_zero ? FIXUP : ITER;
      ITER:    if (r_cnt == CNT_W'(1)) w_state_nxt = CORRECT;
      CORRECT: w_state_nxt = FIXUP;
      FIXUP:   w_state_nxt = DONE;
      DONE:    if (gotResult) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == INIT) || (r_state == ITER) || (r_state == CORRECT) || (r_state == FIXUP);
    done = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_cnt   <= '0;
      r_mode  <= 1'b0;
      r_sgn   <= 1'b0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_dvd  <= dividend;
            r_dvs  <= divisor;
            r_mode <= mode;
            r_sgn  <= signed_op;
          end
        end
        INIT: begin
          r_a     <= '0;
          r_m     <= w_dvs_mag;
          r_q     <= w_dvd_mag;
          r_cnt   <= CNT_W'(WIDTH);
          r_neg_q <= w_dvd_neg ^ w_dvs_neg;
          r_neg_r <= w_dvd_neg;
        end
        ITER: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_mode == MODE_RESTORING) begin
            if (!w_as_sign) begin
              r_a <= w_as_sum;
              r_q <= {w_q_sh, 1'b1};
            end else begin
              r_a <= w_a_sh;
              r_q <= {w_q_sh, 1'b0};
            end
          end else begin
            r_a <= w_as_sum;
            r_q <= {w_q_sh, ~w_as_sign};
          end
        end
        CORRECT: begin
          if ((r_mode == MODE_NONRESTORING) && r_a[WIDTH]) r_a <= w_as_sum;
        end
        FIXUP: begin
          if (w_dvs_zero) begin
            r_quot <= '1;
            r_rem  <= r_dvd;
            r_dbz  <= 1'b1;
            r_ovf  <= 1'b0;
          end else if (w_ovf) begin
            r_quot <= MIN_NEG;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
            r_ovf  <= 1'b1;
          end else begin
            r_quot <= r_neg_q ? -r_q : r_q;
            r_rem  <= r_neg_r ? -r_a[WIDTH-1:0] : r_a[WIDTH-1:0];
            r_dbz  <= 1'b0;
            r_ovf  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

endmodule
